// File: rtl/instr_prefetch.sv
// Instruction prefetch: drives a 1-cycle-latency ROM and buffers fetched words,
// tagged with their address, in a small show-ahead FIFO popped by the processor.
module instr_prefetch #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic                     Clock,
  input  logic                     Reset,
  output logic [ADDR_W-1:0]        rom_addr,
  input  logic [DATA_W-1:0]        rom_data,
  output logic                     ir_valid,
  output logic [DATA_W-1:0]        ir_data,
  output logic [ADDR_W-1:0]        ir_pc,
  input  logic                     ir_ready,
  input  logic                     flush,
  input  logic [ADDR_W-1:0]        flush_pc,
  output logic [$clog2(DEPTH):0]   fill_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] fpc_q, fpc_d;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] last_data_q, last_data_d;
  logic [ADDR_W-1:0] last_pc_q, last_pc_d;

  logic [DATA_W-1:0] mem_data_q [DEPTH];
  logic [ADDR_W-1:0] mem_pc_q   [DEPTH];

  logic [CNT_W:0]    occupancy;
  logic              fire;
  logic              push;
  logic              pop;

  always_comb begin
    rom_addr  = flush ? flush_pc : fpc_q;
    // Occupancy counts the in-flight word so a returning response always has room.
    occupancy = {1'b0, count_q} + {{CNT_W{1'b0}}, pend_q};
    fire      = flush | (occupancy < (CNT_W+1)'(DEPTH));
    push      = pend_q & ~flush;
    ir_valid  = (count_q != '0);
    pop       = ir_valid & ir_ready & ~flush;

    ir_data   = ir_valid ? mem_data_q[rd_ptr_q] : last_data_q;
    ir_pc     = ir_valid ? mem_pc_q[rd_ptr_q]   : last_pc_q;
    last_data_d = ir_data;
    last_pc_d   = ir_pc;
    fill_count  = count_q;

    pend_d    = fire;
    pend_pc_d = pend_pc_q;
    fpc_d     = fpc_q;
    if (fire) begin
      pend_pc_d = rom_addr;
      fpc_d     = rom_addr + ADDR_W'(1);
    end

    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      fpc_q       <= '0;
      pend_q      <= 1'b0;
      pend_pc_q   <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      last_data_q <= '0;
      last_pc_q   <= '0;
    end else begin
      fpc_q       <= fpc_d;
      pend_q      <= pend_d;
      pend_pc_q   <= pend_pc_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      last_data_q <= last_data_d;
      last_pc_q   <= last_pc_d;
    end
  end

  // Storage needs no reset; entries are only visible while count is nonzero.
  always_ff @(posedge Clock) begin
    if (!Reset && push) begin
      mem_data_q[wr_ptr_q] <= rom_data;
      mem_pc_q[wr_ptr_q]   <= pend_pc_q;
    end
  end

endmodule

// File: tb/tb_instr_prefetch.sv
// Directed bench for instr_prefetch with a behavioural ROM holding 16'hA000+addr.
module tb_instr_prefetch;

  logic        Clock;
  logic        Reset;
  logic [4:0]  rom_addr;
  logic [15:0] rom_data;
  logic        ir_valid;
  logic [15:0] ir_data;
  logic [4:0]  ir_pc;
  logic        ir_ready;
  logic        flush;
  logic [4:0]  flush_pc;
  logic [2:0]  fill_count;

  int passed = 0;
  int total  = 0;

  instr_prefetch #(.ADDR_W(5), .DATA_W(16), .DEPTH(4)) dut (
    .Clock(Clock), .Reset(Reset),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .ir_valid(ir_valid), .ir_data(ir_data), .ir_pc(ir_pc), .ir_ready(ir_ready),
    .flush(flush), .flush_pc(flush_pc), .fill_count(fill_count)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  always @(posedge Clock) rom_data <= 16'hA000 + {11'b0, rom_addr};

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic apply_reset();
    Reset = 1'b1; flush = 1'b0; flush_pc = '0;
    repeat (3) step();
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1; flush = 1'b0; flush_pc = '0; ir_ready = 1'b1;
    repeat (3) step();
    total++; if (ir_valid !== 1'b0) $display("FAIL reset_valid got %0b expected 0", ir_valid); else passed++;
    total++; if (fill_count !== 3'd0) $display("FAIL reset_count got %0d expected 0", fill_count); else passed++;
    total++; if (ir_data !== 16'h0) $display("FAIL reset_data got %0h expected 0", ir_data); else passed++;
    total++; if (ir_pc !== 5'd0) $display("FAIL reset_pc got %0d expected 0", ir_pc); else passed++;
    total++; if (rom_addr !== 5'd0) $display("FAIL reset_rom_addr got %0d expected 0", rom_addr); else passed++;
  endtask

  task automatic test_stream();
    Reset = 1'b0;
    step();
    total++; if (ir_valid !== 1'b0) $display("FAIL stream_edge1_valid got %0b expected 0", ir_valid); else passed++;
    step();
    for (int i = 0; i < 6; i++) begin
      total++; if (ir_valid !== 1'b1) $display("FAIL stream_valid[%0d] got %0b expected 1", i, ir_valid); else passed++;
      total++; if (ir_pc !== 5'(i)) $display("FAIL stream_pc[%0d] got %0d expected %0d", i, ir_pc, i); else passed++;
      total++; if (ir_data !== 16'hA000 + 16'(i)) $display("FAIL stream_data[%0d] got %0h expected %0h", i, ir_data, 16'hA000 + 16'(i)); else passed++;
      step();
    end
  endtask

  task automatic test_stall();
    ir_ready = 1'b0;
    apply_reset();
    repeat (8) step();
    total++; if (fill_count !== 3'd4) $display("FAIL stall_count got %0d expected 4", fill_count); else passed++;
    total++; if (rom_addr !== 5'd4) $display("FAIL stall_rom_addr got %0d expected 4", rom_addr); else passed++;
    total++; if (ir_data !== 16'hA000) $display("FAIL stall_data got %0h expected a000", ir_data); else passed++;
    total++; if (ir_pc !== 5'd0) $display("FAIL stall_pc got %0d expected 0", ir_pc); else passed++;
    repeat (3) step();
    total++; if (fill_count !== 3'd4) $display("FAIL stall_count_hold got %0d expected 4", fill_count); else passed++;
    total++; if (rom_addr !== 5'd4) $display("FAIL stall_rom_addr_hold got %0d expected 4", rom_addr); else passed++;
  endtask

  // Drain from full: one pop per cycle, refill starts once space opens, no gaps.
  task automatic test_back_to_back();
    logic [2:0] exp_cnt;
    ir_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      exp_cnt = (i == 0) ? 3'd4 : (i == 1) ? 3'd3 : 3'd2;
      total++; if (ir_valid !== 1'b1) $display("FAIL b2b_valid[%0d] got %0b expected 1", i, ir_valid); else passed++;
      total++; if (ir_pc !== 5'(i)) $display("FAIL b2b_pc[%0d] got %0d expected %0d", i, ir_pc, i); else passed++;
      total++; if (ir_data !== 16'hA000 + 16'(i)) $display("FAIL b2b_data[%0d] got %0h expected %0h", i, ir_data, 16'hA000 + 16'(i)); else passed++;
      total++; if (fill_count !== exp_cnt) $display("FAIL b2b_count[%0d] got %0d expected %0d", i, fill_count, exp_cnt); else passed++;
      step();
    end
  endtask

  task automatic test_flush();
    flush = 1'b1; flush_pc = 5'd20;
    #1;
    total++; if (rom_addr !== 5'd20) $display("FAIL flush_rom_addr got %0d expected 20", rom_addr); else passed++;
    step();
    flush = 1'b0;
    total++; if (ir_valid !== 1'b0) $display("FAIL flush_valid_e1 got %0b expected 0", ir_valid); else passed++;
    total++; if (fill_count !== 3'd0) $display("FAIL flush_count_e1 got %0d expected 0", fill_count); else passed++;
    step();
    for (int i = 0; i < 3; i++) begin
      total++; if (ir_valid !== 1'b1) $display("FAIL flush_valid[%0d] got %0b expected 1", i, ir_valid); else passed++;
      total++; if (ir_pc !== 5'(20 + i)) $display("FAIL flush_pc[%0d] got %0d expected %0d", i, ir_pc, 20 + i); else passed++;
      total++; if (ir_data !== 16'hA000 + 16'(20 + i)) $display("FAIL flush_data[%0d] got %0h expected %0h", i, ir_data, 16'hA000 + 16'(20 + i)); else passed++;
      step();
    end
  endtask

  task automatic test_wrap();
    logic [4:0] exp_pc [4];
    exp_pc[0] = 5'd30; exp_pc[1] = 5'd31; exp_pc[2] = 5'd0; exp_pc[3] = 5'd1;
    flush = 1'b1; flush_pc = 5'd30;
    step();
    flush = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      total++; if (ir_valid !== 1'b1) $display("FAIL wrap_valid[%0d] got %0b expected 1", i, ir_valid); else passed++;
      total++; if (ir_pc !== exp_pc[i]) $display("FAIL wrap_pc[%0d] got %0d expected %0d", i, ir_pc, exp_pc[i]); else passed++;
      total++; if (ir_data !== 16'hA000 + {11'b0, exp_pc[i]}) $display("FAIL wrap_data[%0d] got %0h expected %0h", i, ir_data, 16'hA000 + {11'b0, exp_pc[i]}); else passed++;
      step();
    end
  endtask

  task automatic test_reset_mid_stream();
    Reset = 1'b1; flush = 1'b1; flush_pc = 5'd7; ir_ready = 1'b1;
    step();
    total++; if (ir_valid !== 1'b0) $display("FAIL rst_mid_valid got %0b expected 0", ir_valid); else passed++;
    total++; if (fill_count !== 3'd0) $display("FAIL rst_mid_count got %0d expected 0", fill_count); else passed++;
    total++; if (ir_pc !== 5'd0) $display("FAIL rst_mid_pc got %0d expected 0", ir_pc); else passed++;
    Reset = 1'b0; flush = 1'b0;
    step();
    total++; if (ir_valid !== 1'b0) $display("FAIL rst_mid_e1_valid got %0b expected 0", ir_valid); else passed++;
    step();
    for (int i = 0; i < 2; i++) begin
      total++; if (ir_valid !== 1'b1) $display("FAIL rst_mid_valid[%0d] got %0b expected 1", i, ir_valid); else passed++;
      total++; if (ir_pc !== 5'(i)) $display("FAIL rst_mid_pc[%0d] got %0d expected %0d", i, ir_pc, i); else passed++;
      step();
    end
  endtask

  initial begin
    Reset = 1'b1; flush = 1'b0; flush_pc = '0; ir_ready = 1'b0;
    test_reset();
    test_stream();
    test_stall();
    test_back_to_back();
    test_flush();
    test_wrap();
    test_reset_mid_stream();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
